// File: rtl/switch_scheduler.sv
// ============================================================================
//  Module      : switch_scheduler
//  Description : Per-output round-robin scheduler for the 4-port switch.
//                Pops one input FIFO per output grant, drives output mux
//                select/active, and inserts recovery cycles after each grant.
//                Optional statistics counters under macro SCHED_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module switch_scheduler #(
  parameter int NUM_PORTS      = 4,
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           port_reqs,
  input  logic [3:0]           port0_dst,
  input  logic [3:0]           port1_dst,
  input  logic [3:0]           port2_dst,
  input  logic [3:0]           port3_dst,
  output logic [3:0]           grant_bus,
  output logic [1:0]           mux_sel0,
  output logic [1:0]           mux_sel1,
  output logic [1:0]           mux_sel2,
  output logic [1:0]           mux_sel3,
  output logic                 active0,
  output logic                 active1,
  output logic                 active2,
  output logic                 active3,
  output logic                 err_bad_dst
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
  output logic [CNT_WIDTH-1:0] grant_cnt2,
  output logic [CNT_WIDTH-1:0] grant_cnt3,
  output logic [CNT_WIDTH-1:0] conflict_cnt
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;
  localparam logic [1:0] REC_LAST   = 2'(RECOVER_CYCLES - 1);
  localparam logic [1:0] MASK_INIT  = 2'(RECOVER_CYCLES);

  generate
    if (NUM_PORTS != 4) begin : g_bad_num_ports
      $error("switch_scheduler: only NUM_PORTS=4 is supported");
    end
    if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 3) begin : g_bad_recover
      $error("switch_scheduler: RECOVER_CYCLES must be 1..3");
    end
  endgenerate

  logic [3:0] dst [4];
  logic [3:0] onehot;
  logic [3:0] masked;
  logic [3:0] elig [4];      // elig[j][i]: input i may be granted output j
  logic [1:0] state [4];
  logic [1:0] rcnt  [4];
  logic [1:0] ptr   [4];
  logic [1:0] sel   [4];
  logic [1:0] win   [4];
  logic [1:0] mask_cnt [4];
  logic [3:0] act;
  logic [3:0] found;
  logic [3:0] decide;
  logic [3:0] take;
  logic [3:0] grant_nxt;
  logic       conflict;
  logic       dup;

  assign dst[0] = port0_dst;
  assign dst[1] = port1_dst;
  assign dst[2] = port2_dst;
  assign dst[3] = port3_dst;

  // Eligibility, per-output round-robin search and grant collection
  always_comb begin
    grant_nxt = '0;
    conflict  = 1'b0;
    dup       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      onehot[i] = (dst[i] != 4'd0) && ((dst[i] & (dst[i] - 4'd1)) == 4'd0);
      masked[i] = (mask_cnt[i] != 2'd0);
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        elig[j][i] = port_reqs[i] & onehot[i] & dst[i][j] & ~masked[i];
      end
      // The final recovery cycle doubles as the next arbitration cycle.
      decide[j] = (state[j] == ST_IDLE) ||
                  ((state[j] == ST_RECOVER) && (rcnt[j] == REC_LAST));
      found[j] = 1'b0;
      win[j]   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
        if (!found[j] && elig[j][2'(ptr[j] + 2'(k))]) begin
          found[j] = 1'b1;
          win[j]   = 2'(ptr[j] + 2'(k));
        end
      end
      take[j] = decide[j] & found[j];
      if (decide[j] && ($countones(elig[j]) >= 2)) conflict = 1'b1;
      if (take[j]) begin
        if (grant_nxt[win[j]]) dup = 1'b1;
        grant_nxt[win[j]] = 1'b1;
      end
    end
  end

  // Per-output FSMs, registered outputs and per-input recovery masks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_bus   <= '0;
      act         <= '0;
      err_bad_dst <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        state[j]    <= ST_IDLE;
        rcnt[j]     <= 2'd0;
        ptr[j]      <= 2'd3;
        sel[j]      <= 2'd0;
        mask_cnt[j] <= 2'd0;
      end
    end else begin
      grant_bus   <= grant_nxt;
      act         <= take;
      err_bad_dst <= err_bad_dst | (|(port_reqs & ~onehot));
      for (int i = 0; i < 4; i++) begin
        if (grant_nxt[i])             mask_cnt[i] <= MASK_INIT;
        else if (mask_cnt[i] != 2'd0) mask_cnt[i] <= mask_cnt[i] - 2'd1;
      end
      for (int j = 0; j < 4; j++) begin
        case (state[j])
          ST_IDLE: begin
            if (take[j]) begin
              state[j] <= ST_GRANT;
              sel[j]   <= win[j];
            end
          end
          ST_GRANT: begin
            ptr[j]   <= sel[j];
            rcnt[j]  <= 2'd0;
            state[j] <= ST_RECOVER;
          end
          ST_RECOVER: begin
            if (rcnt[j] == REC_LAST) begin
              if (take[j]) begin
                state[j] <= ST_GRANT;
                sel[j]   <= win[j];
              end else begin
                state[j] <= ST_IDLE;
              end
            end else begin
              rcnt[j] <= rcnt[j] + 2'd1;
            end
          end
          default: state[j] <= ST_IDLE;
        endcase
      end
    end
  end

  assign mux_sel0 = sel[0];
  assign mux_sel1 = sel[1];
  assign mux_sel2 = sel[2];
  assign mux_sel3 = sel[3];
  assign active0  = act[0];
  assign active1  = act[1];
  assign active2  = act[2];
  assign active3  = act[3];

`ifndef SYNTHESIS
  // One-hot destinations must make a double pop impossible
  assert property (@(posedge clk) disable iff (!rst_n) !dup);
`endif

`ifdef SCHED_STATS_EN
  logic [CNT_WIDTH-1:0] gcnt [4];
  logic [CNT_WIDTH-1:0] ccnt;

  // Saturating grant and conflict statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0;
      for (int j = 0; j < 4; j++) gcnt[j] <= '0;
    end else begin
      if (conflict && (ccnt != '1)) ccnt <= ccnt + 1'b1;
      for (int j = 0; j < 4; j++) begin
        if ((state[j] == ST_GRANT) && (gcnt[j] != '1)) gcnt[j] <= gcnt[j] + 1'b1;
      end
    end
  end

  assign grant_cnt0   = gcnt[0];
  assign grant_cnt1   = gcnt[1];
  assign grant_cnt2   = gcnt[2];
  assign grant_cnt3   = gcnt[3];
  assign conflict_cnt = ccnt;
`endif

endmodule

`default_nettype wire
